mem_arbiter: RTL

Shares one single-ported, fixed-latency memory between the fetch stage's instruction port and the memory stage's data port. It accepts one request at a time, runs it through a small issue/wait/respond state machine and returns read data with a one-cycle done pulse. It produces `i_stall` and `d_stall`, the instruction-memory and data-memory stall signals that the fetch, decode and hazard logic consume.

---
 rtl/mem_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, fixed-latency memory between the instruction fetch
// port (i_*) and the data port (d_*). One transaction is in flight at a time.
// It runs through IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. Read data lands in a
// per-port rdata register, and a one-cycle done pulse marks completion in the
// first IDLE cycle after RESP.
//
// Requester handshake: a requester raises its request (i_req, or d_rd/d_wr),
// drives address/data, and holds the request until it sees its done pulse.
// The arbiter captures address/data on the grant edge, so later changes are
// ignored. While a port's done is high, that port's request is not sampled.
// This lets a requester drop or re-raise its request in the cycle after done
// without producing a duplicate grant.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties. A one-bit last-grant
//                               register resets to "instruction", so the
//                               first tie goes to data.
//                  undefined -> fixed priority, data over instruction.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from the mem_en cycle to valid mem_rdata (>= 1)
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   i_req, i_addr       fetch request / address
//   i_rdata, i_done     fetched word / completion pulse
//   i_stall             i_req & ~i_done
//   d_rd, d_wr          data read / write request (both high = write + err)
//   d_addr, d_wdata     data address / store data
//   d_rdata, d_done     load data / completion pulse
//   d_stall             (d_rd | d_wr) & ~d_done
//   mem_en, mem_wr      memory strobe / write select (only in ISSUE)
//   mem_addr, mem_wdata memory address / write data (zero outside ISSUE)
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   busy                transaction in flight (state != IDLE)
//   err                 sticky: d_rd and d_wr both high in a sampled IDLE cycle
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The counter only ever holds values up to MEM_LAT-1.
    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                owner_d_q;   // 1: data port owns the transaction
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                i_pend;
    logic                d_pend;
    logic                gnt_i;
    logic                gnt_d;
    logic                issue;

    // A port whose done is high this cycle has just been served; its request
    // is still up only because the requester has not yet seen the pulse.
    assign i_pend = i_req & ~i_done;
    assign d_pend = (d_rd | d_wr) & ~d_done;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;   // 1: data port was granted last

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b0;
        end else if (gnt_d) begin
            last_d_q <= 1'b1;
        end else if (gnt_i) begin
            last_d_q <= 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Next-state and grant logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_pend && i_pend) begin
`ifdef MEM_ARB_RR_EN
                    if (last_d_q) begin
                        gnt_i = 1'b1;
                    end else begin
                        gnt_d = 1'b1;
                    end
`else
                    // The load/store is the older instruction.
                    gnt_d = 1'b1;
`endif
                end else if (d_pend) begin
                    gnt_d = 1'b1;
                end else if (i_pend) begin
                    gnt_i = 1'b1;
                end
                if (gnt_d || gnt_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Transaction latch, latency counter, response registers, err
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;

            if (gnt_d) begin
                owner_d_q <= 1'b1;
                wr_q      <= d_wr;   // rd+wr together resolves to a write
                addr_q    <= d_addr;
                wdata_q   <= d_wdata;
            end else if (gnt_i) begin
                owner_d_q <= 1'b0;
                wr_q      <= 1'b0;
                addr_q    <= i_addr;
                wdata_q   <= '0;
            end

            if ((state_q == ST_IDLE) && d_rd && d_wr && !d_done) begin
                err <= 1'b1;
            end

            case (state_q)
                ST_ISSUE: cnt_q <= CNT_LOAD;
                ST_WAIT:  cnt_q <= cnt_q - CNT_ONE;
                ST_RESP: begin
                    // mem_rdata is valid in this cycle: MEM_LAT after ISSUE.
                    if (owner_d_q) begin
                        d_done <= 1'b1;
                        if (!wr_q) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        i_done  <= 1'b1;
                        i_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Combinational outputs
    // ---------------------------------------------------------------------
    assign issue     = (state_q == ST_ISSUE);
    assign mem_en    = issue;
    assign mem_wr    = issue & wr_q;
    assign mem_addr  = issue ? addr_q  : '0;
    assign mem_wdata = issue ? wdata_q : '0;

    assign busy      = (state_q != ST_IDLE);
    assign i_stall   = i_req & ~i_done;
    assign d_stall   = (d_rd | d_wr) & ~d_done;
    assign dbg_state = state_q;

endmodule
